nco_oscillator: RTL and testbench
=================================

# nco_oscillator

Parametrised phase-accumulator oscillator (NCO) for the synth voice path, generalising the fixed toggle-counter square oscillator. Each cycle a phase accumulator advances by a tuning increment and produces a registered multi-bit waveform (saw, triangle, square, variable-duty pulse), a 1-bit logic output, and a wrap strobe. Tuning changes are double-buffered so pitch updates take effect only at a cycle boundary of the waveform. Hard-sync and enable inputs allow chaining voices and gating the oscillator.

## Interface

- ACC_WIDTH, 24, phase accumulator width in bits.
- INC_WIDTH, 18, tuning increment width. Must satisfy INC_WIDTH <= ACC_WIDTH.
- OUT_WIDTH, 8, waveform output width. Must satisfy 2 <= OUT_WIDTH <= ACC_WIDTH.

- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = accumulator advances; 0 = phase frozen, outputs still update.
- tuning_increment  in  INC_WIDTH  new increment value, zero-extended to ACC_WIDTH.
- tuning_load  in  1  one-cycle strobe that captures tuning_increment.
- wave_sel  in  2  0 = saw, 1 = triangle, 2 = square, 3 = pulse.
- duty  in  OUT_WIDTH  pulse threshold for wave_sel = 3.
- sync_in  in  1  level-sampled hard sync; resets phase.
- wave  out  OUT_WIDTH  registered waveform sample.
- out  out  1  registered 1-bit oscillator output.
- wrap  out  1  registered one-cycle strobe on accumulator overflow.

## Operation

- State registers:
  - acc (ACC_WIDTH)
  - inc_active (ACC_WIDTH)
  - inc_pending (ACC_WIDTH)
  - wave, out, wrap
- Reset: acc, inc_active, inc_pending, wave, out and wrap all clear to 0. rst overrides every other input in the same cycle, including mid-period.
- tuning_load:
  - Normally writes the zero-extended tuning_increment into inc_pending.
  - If inc_active == 0 (stalled, e.g. after reset), it also writes inc_active directly that same cycle.
- Accumulator update priority, evaluated each cycle when not in reset:
  1. If sync_in = 1: acc <= 0 and inc_active <= pending value (see below). The wrap flag is not asserted.
  2. Else if enable = 1: {carry, acc} <= acc + inc_active, modulo 2^ACC_WIDTH. If carry = 1, inc_active <= pending value. The wrap flag equals carry.
  3. Else: acc holds, inc_active holds, and the wrap flag is 0.
- Pending value: tuning_increment if tuning_load is high in the same cycle, otherwise inc_pending. The newest load wins on a collision with wrap or sync.
- The increment used for the wrapping addition is always the old inc_active; the new one applies from the next step.
- Phase p = acc[ACC_WIDTH-1 -: OUT_WIDTH], taken from the registered acc.
- Waveform, computed from p and registered into wave:
  - saw: p.
  - triangle: p[MSB] ? ~{p[OUT_WIDTH-2:0],1'b0} : {p[OUT_WIDTH-2:0],1'b0}.
  - square: all ones if p[MSB], else 0.
  - pulse: all ones if p < duty (unsigned), else 0. duty = 0 gives a constant 0.
- out: (p < duty) when wave_sel = 3, otherwise p[MSB]. Note this is high in the second half-period for non-pulse modes.
- Output frequency: f_clk * inc_active / 2^ACC_WIDTH. inc_active = 0 holds the phase constant.

## Timing

- acc updates at edge N. wave and out reflect that acc at edge N+1, a fixed latency of 1 cycle.
- wrap is registered alongside acc. It is high for exactly one cycle: the cycle in which acc holds the post-overflow value.
- wave_sel and duty changes are reflected in wave and out one cycle after they are sampled, with no phase disturbance.
- Sync asserted at edge N: acc = 0 after N, and wave reflects p = 0 after N+1. Sync held high keeps acc at 0.
- Pitch change from tuning_load while inc_active != 0: no effect until the next wrap or sync. If neither occurs, inc_pending holds indefinitely.

## Test plan

- **Reset and stall start.** Apply rst, then enable = 1 with no load -> acc, wave, out and wrap stay 0 indefinitely. Then load 0x100000 -> inc_active = 0x100000 the next cycle, and acc steps by 0x100000 per cycle.
- **Square period.** Use inc = 0x100000 with OUT_WIDTH = 8 -> wrap every 16 cycles, out 8 cycles low then 8 high, saw wave steps 0x00, 0x10, ..., 0xF0.
- **Deferred retune.** With inc = 0x100000, load 0x200000 when acc = 0x300000 -> steps continue at 0x100000 until wrap; after wrap the period is 8 cycles. A load coinciding with the wrap cycle also applies from the next step.
- **Pulse and triangle.** With inc = 0x100000 and wave_sel = 3, duty = 0x40 -> out high 4 of every 16 cycles. With wave_sel = 1 -> p = 0x40 gives wave 0x80, and p = 0xC0 gives wave 0x7F.
- **Hard sync and enable.** Assert sync_in for 1 cycle at acc = 0x700000 -> acc = 0 next cycle with no wrap pulse. Drop enable for 5 cycles -> acc frozen and wrap = 0; resume from the same phase.
- **Reset mid-operation.** Assert rst while inc_pending != inc_active and acc != 0 -> all state returns to 0 in one cycle, and the pending pitch is discarded.

Source files
------------

// File: rtl/nco_oscillator.sv
// Phase-accumulator oscillator: saw/triangle/square/pulse waveforms, a 1-bit output and a wrap
// strobe, with pitch changes deferred to the waveform cycle boundary (wrap or hard sync).
module nco_oscillator #(
    parameter int ACC_WIDTH = 24,
    parameter int INC_WIDTH = 18,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [INC_WIDTH-1:0] tuning_increment,
    input  logic                 tuning_load,
    input  logic [1:0]           wave_sel,
    input  logic [OUT_WIDTH-1:0] duty,
    input  logic                 sync_in,
    output logic [OUT_WIDTH-1:0] wave,
    output logic                 out,
    output logic                 wrap
);
    localparam logic [1:0] SEL_SAW    = 2'd0;
    localparam logic [1:0] SEL_TRI    = 2'd1;
    localparam logic [1:0] SEL_SQUARE = 2'd2;

    logic [ACC_WIDTH-1:0] acc_r;
    logic [ACC_WIDTH-1:0] inc_active_r;
    logic [ACC_WIDTH-1:0] inc_pending_r;
    logic [ACC_WIDTH-1:0] acc_next_s;
    logic [ACC_WIDTH-1:0] inc_active_next_s;
    logic [ACC_WIDTH-1:0] inc_pending_next_s;
    logic [ACC_WIDTH-1:0] inc_load_s;
    logic [ACC_WIDTH-1:0] pending_s;
    logic [ACC_WIDTH:0]   sum_s;
    logic                 wrap_next_s;
    logic [OUT_WIDTH-1:0] phase_s;
    logic [OUT_WIDTH-1:0] tri_s;
    logic [OUT_WIDTH-1:0] wave_next_s;
    logic                 below_duty_s;
    logic                 out_next_s;

    // Phase step and increment hand-over; the newest load beats the stored pending value.
    always_comb begin
        inc_load_s                  = {ACC_WIDTH{1'b0}};
        inc_load_s[INC_WIDTH-1:0]   = tuning_increment;
        sum_s                       = {1'b0, acc_r} + {1'b0, inc_active_r};
        acc_next_s                  = acc_r;
        inc_active_next_s           = inc_active_r;
        wrap_next_s                 = 1'b0;
        if (tuning_load) begin
            pending_s          = inc_load_s;
            inc_pending_next_s = inc_load_s;
        end else begin
            pending_s          = inc_pending_r;
            inc_pending_next_s = inc_pending_r;
        end
        // A stalled oscillator has no wrap to wait for, so a load starts it directly.
        if (tuning_load && (inc_active_r == {ACC_WIDTH{1'b0}})) begin
            inc_active_next_s = inc_load_s;
        end else begin
            inc_active_next_s = inc_active_r;
        end
        if (sync_in) begin
            acc_next_s        = {ACC_WIDTH{1'b0}};
            inc_active_next_s = pending_s;
        end else if (enable) begin
            acc_next_s  = sum_s[ACC_WIDTH-1:0];
            wrap_next_s = sum_s[ACC_WIDTH];
            if (sum_s[ACC_WIDTH]) begin
                inc_active_next_s = pending_s;
            end else begin
                acc_next_s = sum_s[ACC_WIDTH-1:0];
            end
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Waveform shaping from the registered phase.
    always_comb begin
        phase_s      = acc_r[ACC_WIDTH-1 -: OUT_WIDTH];
        below_duty_s = (phase_s < duty);
        if (phase_s[OUT_WIDTH-1]) begin
            tri_s = ~{phase_s[OUT_WIDTH-2:0], 1'b0};
        end else begin
            tri_s = {phase_s[OUT_WIDTH-2:0], 1'b0};
        end
        case (wave_sel)
            SEL_SAW:    wave_next_s = phase_s;
            SEL_TRI:    wave_next_s = tri_s;
            SEL_SQUARE: wave_next_s = {OUT_WIDTH{phase_s[OUT_WIDTH-1]}};
            default:    wave_next_s = {OUT_WIDTH{below_duty_s}};
        endcase
        if (wave_sel == 2'd3) begin
            out_next_s = below_duty_s;
        end else begin
            out_next_s = phase_s[OUT_WIDTH-1];
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r         <= {ACC_WIDTH{1'b0}};
            inc_active_r  <= {ACC_WIDTH{1'b0}};
            inc_pending_r <= {ACC_WIDTH{1'b0}};
            wave          <= {OUT_WIDTH{1'b0}};
            out           <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            acc_r         <= acc_next_s;
            inc_active_r  <= inc_active_next_s;
            inc_pending_r <= inc_pending_next_s;
            wave          <= wave_next_s;
            out           <= out_next_s;
            wrap          <= wrap_next_s;
        end
    end
endmodule

// File: tb/tb_nco_oscillator.sv
// Self-checking bench for nco_oscillator: directed scenarios plus randomized stimulus,
// every cycle compared against an arithmetic reference model of the oscillator.
module tb_nco_oscillator;
    localparam int ACC_WIDTH = 24;
    localparam int INC_WIDTH = 22;
    localparam int OUT_WIDTH = 8;
    localparam longint MOD  = 64'd1 << ACC_WIDTH;
    localparam longint FULL = (64'd1 << OUT_WIDTH) - 64'd1;
    localparam longint HALF = 64'd1 << (OUT_WIDTH - 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic [INC_WIDTH-1:0] tuning_increment;
    logic                 tuning_load;
    logic [1:0]           wave_sel;
    logic [OUT_WIDTH-1:0] duty;
    logic                 sync_in;
    logic [OUT_WIDTH-1:0] wave;
    logic                 out;
    logic                 wrap;

    int     n_cmp = 0;
    int     n_err = 0;
    longint m_acc, m_active, m_pending, e_wave;
    longint e_out, e_wrap;
    int     wraps[$];

    always #5 clk = ~clk;

    nco_oscillator #(.ACC_WIDTH(ACC_WIDTH), .INC_WIDTH(INC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk(clk), .rst(rst), .enable(enable), .tuning_increment(tuning_increment),
        .tuning_load(tuning_load), .wave_sel(wave_sel), .duty(duty), .sync_in(sync_in),
        .wave(wave), .out(out), .wrap(wrap)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint wave_ref(input longint p, input int sel, input longint d);
        case (sel)
            0:       return p;
            1:       return (p < HALF) ? 2 * p : FULL - 2 * (p - HALF);
            2:       return (p >= HALF) ? FULL : 64'd0;
            default: return (p < d) ? FULL : 64'd0;
        endcase
    endfunction

    // One clock: advance the model with the inputs present at the edge, then compare outputs.
    task automatic step();
        longint p, pend, old_active, nxt;
        @(posedge clk);
        if (rst) begin
            m_acc = 0; m_active = 0; m_pending = 0;
            e_wave = 0; e_out = 0; e_wrap = 0;
        end else begin
            p          = m_acc / (MOD >> OUT_WIDTH);
            e_wave     = wave_ref(p, int'(wave_sel), longint'(duty));
            e_out      = (wave_sel == 2'd3) ? longint'(p < longint'(duty)) : longint'(p >= HALF);
            old_active = m_active;
            pend       = tuning_load ? longint'(tuning_increment) : m_pending;
            if (tuning_load) begin
                m_pending = longint'(tuning_increment);
                if (old_active == 0) m_active = longint'(tuning_increment);
            end
            if (sync_in) begin
                m_acc = 0; m_active = pend; e_wrap = 0;
            end else if (enable) begin
                nxt    = m_acc + old_active;
                e_wrap = (nxt >= MOD) ? 1 : 0;
                m_acc  = nxt % MOD;
                if (e_wrap == 1) m_active = pend;
            end else begin
                e_wrap = 0;
            end
        end
        #1;
        check_eq("wave", 64'(wave), e_wave);
        check_eq("out", 64'(out), e_out);
        check_eq("wrap", 64'(wrap), e_wrap);
    endtask

    task automatic record_wraps(input int n);
        wraps.delete();
        for (int i = 0; i < n; i++) begin
            step();
            if (wrap === 1'b1) wraps.push_back(i);
        end
    endtask

    initial begin
        int bad, ones;
        logic [OUT_WIDTH-1:0] held;
        rst = 1'b1; enable = 1'b0; tuning_increment = '0; tuning_load = 1'b0;
        wave_sel = 2'd0; duty = '0; sync_in = 1'b0;
        step(); step();

        // Stalled start: enable without any load keeps everything at zero.
        rst = 1'b0; enable = 1'b1; bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (wave !== '0 || out !== 1'b0 || wrap !== 1'b0) bad++;
        end
        check_eq("stall_quiet", 64'(bad), 64'd0);

        // First load starts the stalled oscillator directly; square period of 16.
        wave_sel = 2'd2; tuning_increment = 22'h100000; tuning_load = 1'b1;
        step();
        tuning_load = 1'b0;
        record_wraps(40);
        check_eq("sq_period", (wraps.size() >= 2) ? 64'(wraps[1] - wraps[0]) : 64'hFFFF, 64'd16);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (out === 1'b1) ones++;
        end
        check_eq("sq_half_high", 64'(ones), 64'd8);

        // Pulse with duty 0x40 is high a quarter of the period, then triangle.
        wave_sel = 2'd3; duty = 8'h40;
        step();
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (out === 1'b1) ones++;
        end
        check_eq("pulse_high", 64'(ones), 64'd4);
        wave_sel = 2'd1;
        for (int i = 0; i < 18; i++) step();

        // Deferred retune: load 0x200000 at acc = 0x300000, applied only after the wrap.
        wave_sel = 2'd0;
        for (int i = 0; i < 40 && m_acc != 64'h300000; i++) step();
        check_eq("retune_reach", m_acc, 64'h300000);
        tuning_increment = 22'h200000; tuning_load = 1'b1;
        step();
        tuning_load = 1'b0;
        record_wraps(30);
        check_eq("retune_first_wrap", (wraps.size() >= 1) ? 64'(wraps[0]) : 64'hFFFF, 64'd11);
        check_eq("retune_period", (wraps.size() >= 2) ? 64'(wraps[1] - wraps[0]) : 64'hFFFF, 64'd8);

        // Load coinciding with the wrap edge applies from the following step.
        for (int i = 0; i < 20 && (m_acc + m_active) < MOD; i++) step();
        tuning_increment = 22'h100000; tuning_load = 1'b1;
        step();
        tuning_load = 1'b0;
        record_wraps(20);
        check_eq("wrapload_first_wrap", (wraps.size() >= 1) ? 64'(wraps[0]) : 64'hFFFF, 64'd15);

        // Hard sync at acc = 0x700000: phase to zero with no wrap pulse.
        for (int i = 0; i < 40 && m_acc != 64'h700000; i++) step();
        check_eq("sync_reach", m_acc, 64'h700000);
        sync_in = 1'b1;
        step();
        check_eq("sync_no_wrap", 64'(wrap), 64'd0);
        sync_in = 1'b0;
        step();
        check_eq("sync_wave_zero", 64'(wave), 64'd0);

        // Enable low for 5 cycles freezes the phase.
        for (int i = 0; i < 5; i++) step();
        enable = 1'b0;
        step();
        held = wave; bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wave !== held || wrap !== 1'b0) bad++;
        end
        check_eq("freeze_stable", 64'(bad), 64'd0);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Reset mid-period with a pending retune: the pending pitch is discarded.
        tuning_increment = 22'h200000; tuning_load = 1'b1;
        step();
        tuning_load = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0; bad = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (wave !== '0 || wrap !== 1'b0) bad++;
        end
        check_eq("reset_discard", 64'(bad), 64'd0);

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 299) == 0);
            sync_in          = ($urandom_range(0, 39) == 0);
            enable           = ($urandom_range(0, 7) != 0);
            tuning_load      = ($urandom_range(0, 24) == 0);
            tuning_increment = ($urandom_range(0, 9) == 0) ? '0 : INC_WIDTH'($urandom_range(0, (1 << INC_WIDTH) - 1));
            if ($urandom_range(0, 15) == 0) wave_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) duty = OUT_WIDTH'($urandom_range(0, 255));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
